// File: rtl/pdm_cic_ctrl.sv
// Stereo PDM front-end sequencer: PDM clock generation, bit demux into two CIC
// decimators, atomic filter reconfiguration with settle discard, output serializer.
module pdm_cic_ctrl #(
    parameter int SETTLE_SAMPLES = 5,
    parameter int DIV_WIDTH      = 8
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 cfg_en_i,
    input  logic                 cfg_commit_i,
    input  logic [DIV_WIDTH-1:0] cfg_clkdiv_i,
    input  logic [9:0]           cfg_decimation_i,
    input  logic [2:0]           cfg_shift_i,
    input  logic                 cfg_stereo_i,
    output logic                 pdm_clk_o,
    input  logic                 pdm_data_i,
    output logic                 cic_update_o,
    output logic [9:0]           cic_decimation_o,
    output logic [2:0]           cic_shift_o,
    output logic [1:0]           cic_data_o,
    output logic                 cic_valid_o,
    input  logic [15:0]          cic0_data_i,
    input  logic                 cic0_valid_i,
    input  logic [15:0]          cic1_data_i,
    input  logic                 cic1_valid_i,
    output logic [15:0]          out_data_o,
    output logic                 out_ch_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic                 overflow_o,
    output logic                 busy_o
);

    localparam int SCW = $clog2(SETTLE_SAMPLES + 1);

    typedef enum logic [2:0] {IDLE, UPDATE, SETTLE, RUN, STOP} state_t;

    state_t               state;
    logic [DIV_WIDTH-1:0] sh_clkdiv;
    logic                 sh_stereo;
    logic [DIV_WIDTH-1:0] div_cnt;
    logic [DIV_WIDTH-1:0] div_max;
    logic                 running;
    logic                 div_tick;
    logic                 fell_q;
    logic                 rose_q;
    logic                 ch0_bit;
    logic [SCW-1:0]       settle_cnt;
    logic                 pend_upd;
    logic                 pend_stop;
    logic [15:0]          hold0;
    logic [15:0]          hold1;
    logic                 pend0;
    logic                 pend1;
    logic                 cur;

    logic hs, hs0, hs1, v0, v1, load0, load1, drop0, drop1;
    logic pend0_n, pend1_n, cur_n;

    assign div_max  = (sh_clkdiv == '0) ? DIV_WIDTH'(1) : sh_clkdiv;
    assign running  = (state == SETTLE) || (state == RUN);
    assign div_tick = running && (div_cnt == div_max);

    // Output stream: a sample transfers on a cycle with out_valid_o && out_ready_i;
    // once raised, out_valid_o, out_data_o and out_ch_o stay fixed until that cycle.
    assign out_valid_o = pend0 | pend1;
    assign out_ch_o    = cur;
    assign out_data_o  = cur ? hold1 : hold0;

    always_comb begin
        hs      = out_valid_o & out_ready_i;
        hs0     = hs & ~cur;
        hs1     = hs & cur;
        v0      = (state == RUN) & cic0_valid_i;
        v1      = (state == RUN) & sh_stereo & cic1_valid_i;
        load0   = v0 & (~pend0 | hs0);
        load1   = v1 & (~pend1 | hs1);
        drop0   = v0 & pend0 & ~hs0;
        drop1   = v1 & pend1 & ~hs1;
        pend0_n = (pend0 & ~hs0) | load0;
        pend1_n = (pend1 & ~hs1) | load1;
        // After ch0 leaves, an older ch1 goes next so a pair is never split by a newer ch0.
        if (out_valid_o && !out_ready_i) cur_n = cur;
        else if (hs0 && pend1_n)         cur_n = 1'b1;
        else if (pend0_n)                cur_n = 1'b0;
        else                             cur_n = pend1_n;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state            <= IDLE;
            sh_clkdiv        <= '0;
            sh_stereo        <= 1'b0;
            cic_decimation_o <= '0;
            cic_shift_o      <= '0;
            div_cnt          <= '0;
            pdm_clk_o        <= 1'b0;
            fell_q           <= 1'b0;
            rose_q           <= 1'b0;
            ch0_bit          <= 1'b0;
            cic_update_o     <= 1'b0;
            cic_valid_o      <= 1'b0;
            cic_data_o       <= '0;
            settle_cnt       <= '0;
            pend_upd         <= 1'b0;
            pend_stop        <= 1'b0;
            hold0            <= '0;
            hold1            <= '0;
            pend0            <= 1'b0;
            pend1            <= 1'b0;
            cur              <= 1'b0;
            overflow_o       <= 1'b0;
            busy_o           <= 1'b0;
        end else begin
            if (cfg_commit_i) begin
                sh_clkdiv        <= cfg_clkdiv_i;
                sh_stereo        <= cfg_stereo_i;
                cic_decimation_o <= cfg_decimation_i;
                cic_shift_o      <= cfg_shift_i;
            end
            if (drop0 || drop1)    overflow_o <= 1'b1;
            else if (cfg_commit_i) overflow_o <= 1'b0;

            cic_update_o <= 1'b0;
            cic_valid_o  <= 1'b0;

            if (running) begin
                if (div_tick) begin
                    div_cnt   <= '0;
                    pdm_clk_o <= ~pdm_clk_o;
                end else begin
                    div_cnt <= div_cnt + DIV_WIDTH'(1);
                end
                fell_q <= div_tick & pdm_clk_o;
                rose_q <= div_tick & ~pdm_clk_o;
            end else begin
                div_cnt   <= '0;
                pdm_clk_o <= 1'b0;
                fell_q    <= 1'b0;
                rose_q    <= 1'b0;
            end
            // Capture one cycle after each edge so the bit reflects the new phase.
            if (fell_q) ch0_bit <= pdm_data_i;
            if (rose_q && running) begin
                cic_valid_o <= 1'b1;
                cic_data_o  <= {sh_stereo & pdm_data_i, ch0_bit};
            end

            pend0 <= pend0_n;
            pend1 <= pend1_n;
            cur   <= cur_n;
            if (load0) hold0 <= cic0_data_i;
            if (load1) hold1 <= cic1_data_i;

            case (state)
                IDLE: begin
                    pend_upd  <= 1'b0;
                    pend_stop <= 1'b0;
                    if (cfg_en_i) begin
                        state        <= UPDATE;
                        cic_update_o <= 1'b1;
                        busy_o       <= 1'b1;
                    end
                end
                UPDATE: begin
                    state      <= SETTLE;
                    settle_cnt <= '0;
                    ch0_bit    <= 1'b0;
                    hold0      <= '0;
                    hold1      <= '0;
                    pend0      <= 1'b0;
                    pend1      <= 1'b0;
                    cur        <= 1'b0;
                    pend_upd   <= 1'b0;
                    pend_stop  <= 1'b0;
                end
                SETTLE: begin
                    if (cfg_commit_i) pend_upd  <= 1'b1;
                    if (!cfg_en_i)    pend_stop <= 1'b1;
                    if (cic0_valid_i) begin
                        if (settle_cnt == SCW'(SETTLE_SAMPLES - 1)) state <= RUN;
                        else settle_cnt <= settle_cnt + SCW'(1);
                    end
                end
                RUN: begin
                    if (cfg_commit_i) pend_upd  <= 1'b1;
                    if (!cfg_en_i)    pend_stop <= 1'b1;
                    // Period end is the strobe cycle; stop wins over a pending update.
                    if (cic_valid_o) begin
                        if (pend_stop || !cfg_en_i) begin
                            state <= STOP;
                        end else if (pend_upd || cfg_commit_i) begin
                            state        <= UPDATE;
                            cic_update_o <= 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (!pend0 && !pend1) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pdm_cic_ctrl.sv
// Directed bench for pdm_cic_ctrl: vector table for clocking/demux, plus
// sequences for settle discard, overflow, reconfiguration, stop and reset.
module tb_pdm_cic_ctrl;

    localparam int SETTLE = 5;
    localparam int K      = 16;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic        cfg_en_i = 1'b0, cfg_commit_i = 1'b0, cfg_stereo_i = 1'b0;
    logic [7:0]  cfg_clkdiv_i = '0;
    logic [9:0]  cfg_decimation_i = '0;
    logic [2:0]  cfg_shift_i = '0;
    logic        pdm_clk_o, pdm_data_i = 1'b0;
    logic        cic_update_o, cic_valid_o;
    logic [9:0]  cic_decimation_o;
    logic [2:0]  cic_shift_o;
    logic [1:0]  cic_data_o;
    logic [15:0] cic0_data_i = '0, cic1_data_i = '0;
    logic        cic0_valid_i = 1'b0, cic1_valid_i = 1'b0;
    logic [15:0] out_data_o;
    logic        out_ch_o, out_valid_o, out_ready_i = 1'b0;
    logic        overflow_o, busy_o;

    always #5 clk_i = ~clk_i;

    pdm_cic_ctrl #(.SETTLE_SAMPLES(SETTLE), .DIV_WIDTH(8)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .cfg_en_i(cfg_en_i), .cfg_commit_i(cfg_commit_i),
        .cfg_clkdiv_i(cfg_clkdiv_i), .cfg_decimation_i(cfg_decimation_i),
        .cfg_shift_i(cfg_shift_i), .cfg_stereo_i(cfg_stereo_i), .pdm_clk_o(pdm_clk_o),
        .pdm_data_i(pdm_data_i), .cic_update_o(cic_update_o),
        .cic_decimation_o(cic_decimation_o), .cic_shift_o(cic_shift_o),
        .cic_data_o(cic_data_o), .cic_valid_o(cic_valid_o), .cic0_data_i(cic0_data_i),
        .cic0_valid_i(cic0_valid_i), .cic1_data_i(cic1_data_i), .cic1_valid_i(cic1_valid_i),
        .out_data_o(out_data_o), .out_ch_o(out_ch_o), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .overflow_o(overflow_o), .busy_o(busy_o)
    );

    typedef struct {
        logic [7:0] clkdiv;
        logic       lo;
        logic       hi;
        logic       stereo;
        logic [1:0] exp_data;
        int         exp_period;
    } vec_t;

    vec_t        vecs[6];
    logic [16:0] exp_q[$];
    int          checks = 0, errors = 0;
    logic        lo_v = 1'b0, hi_v = 1'b0;
    bit          model_en = 0, sb_en = 0, exp_stereo = 1;
    int          strobe_cnt = 0, delay_c = 0, discard = SETTLE, seq = 0;
    int          pulse_n = 0, pop_n = 0, upd_seen = 0;
    logic        h0 = 1'b0, h1 = 1'b0, h2 = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_i);
        #1;
        h2 = h1;
        h1 = h0;
        h0 = pdm_clk_o;
        if (cic_update_o) upd_seen++;
    endtask

    task automatic wait_strobe(input int limit, output bit ok);
        ok = 0;
        for (int i = 0; i < limit; i++) begin
            step();
            if (cic_valid_o) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic wait_pulse(input int target, input int limit, output bit ok);
        ok = 0;
        for (int i = 0; i < limit; i++) begin
            step();
            if (pulse_n >= target) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic wait_pops(input int target, input int limit, output bit ok);
        ok = 0;
        for (int i = 0; i < limit; i++) begin
            step();
            if (pop_n >= target) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rstn_i = 1'b0;
        cfg_en_i = 1'b0;
        cfg_commit_i = 1'b0;
        step();
        step();
        rstn_i = 1'b1;
        step();
    endtask

    task automatic commit();
        cfg_commit_i = 1'b1;
        step();
        cfg_commit_i = 1'b0;
    endtask

    // PDM microphone: drives lo_v while the clock is low and hi_v while high.
    always @(negedge clk_i) pdm_data_i = pdm_clk_o ? hi_v : lo_v;

    // Filter stand-in: one output pair a few cycles after every K-th input strobe.
    always @(negedge clk_i) begin
        #2;
        cic0_valid_i = 1'b0;
        cic1_valid_i = 1'b0;
        if (!rstn_i || !model_en) begin
            strobe_cnt = 0;
            delay_c = 0;
            discard = SETTLE;
        end else if (cic_update_o) begin
            strobe_cnt = 0;
            delay_c = 0;
            discard = SETTLE;
        end else if (cic_valid_o) begin
            strobe_cnt++;
            if (strobe_cnt == K) begin
                strobe_cnt = 0;
                delay_c = 3;
            end
        end else if (delay_c > 0) begin
            delay_c--;
            if (delay_c == 0) begin
                cic0_valid_i = 1'b1;
                cic1_valid_i = 1'b1;
                cic0_data_i = 16'h1000 + 16'(seq);
                cic1_data_i = 16'h2000 + 16'(seq);
                seq++;
                pulse_n++;
                if (discard > 0) discard--;
                else begin
                    exp_q.push_back({1'b0, cic0_data_i});
                    if (exp_stereo) exp_q.push_back({1'b1, cic1_data_i});
                end
            end
        end
    end

    // Output sink / scoreboard.
    always @(negedge clk_i) begin
        logic [16:0] e;
        #2;
        if (sb_en && rstn_i && out_valid_o && out_ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_unexpected: got ch%0d %0h, none expected", out_ch_o, out_data_o);
            end else begin
                e = exp_q.pop_front();
                check("out_sample", {15'd0, out_ch_o, out_data_o}, {15'd0, e});
                pop_n++;
            end
        end
    end

    initial begin
        bit          ok;
        bit          early;
        int          n;
        int          p0;
        logic [15:0] e16;

        vecs[0] = '{8'd3, 1'b1, 1'b0, 1'b1, 2'b01, 8};
        vecs[1] = '{8'd3, 1'b0, 1'b1, 1'b1, 2'b10, 8};
        vecs[2] = '{8'd1, 1'b1, 1'b1, 1'b1, 2'b11, 4};
        vecs[3] = '{8'd1, 1'b1, 1'b1, 1'b0, 2'b01, 4};
        vecs[4] = '{8'd0, 1'b0, 1'b1, 1'b1, 2'b10, 4};
        vecs[5] = '{8'd5, 1'b1, 1'b1, 1'b0, 2'b01, 12};

        rstn_i = 1'b0;
        step();
        check("rst_pdm_clk", pdm_clk_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_update", cic_update_o, 0);
        check("rst_cic_valid", cic_valid_o, 0);
        check("rst_cic_data", cic_data_o, 0);
        check("rst_out_valid", out_valid_o, 0);
        check("rst_out_data", out_data_o, 0);
        check("rst_overflow", overflow_o, 0);
        check("rst_decimation", cic_decimation_o, 0);
        check("rst_shift", cic_shift_o, 0);

        foreach (vecs[v]) begin
            do_reset();
            cfg_clkdiv_i = vecs[v].clkdiv;
            cfg_stereo_i = vecs[v].stereo;
            cfg_decimation_i = 10'd10;
            lo_v = vecs[v].lo;
            hi_v = vecs[v].hi;
            commit();
            upd_seen = 0;
            cfg_en_i = 1'b1;
            wait_strobe(200, ok);
            check($sformatf("v%0d_first_strobe", v), ok, 1);
            for (int s = 0; s < 2; s++) begin
                n = 0;
                ok = 0;
                for (int i = 0; i < 100; i++) begin
                    step();
                    n++;
                    if (cic_valid_o) begin
                        ok = 1;
                        break;
                    end
                end
                check($sformatf("v%0d_period", v), n, vecs[v].exp_period);
                check($sformatf("v%0d_data", v), cic_data_o, vecs[v].exp_data);
                check($sformatf("v%0d_after_rise", v), {h2, h1, h0}, 3'b011);
            end
            check($sformatf("v%0d_update_pulses", v), upd_seen, 1);
        end

        // Settle discard and ch0-before-ch1 ordering.
        do_reset();
        cfg_clkdiv_i = 8'd3;
        cfg_decimation_i = 10'd10;
        cfg_shift_i = 3'd2;
        cfg_stereo_i = 1'b1;
        exp_stereo = 1;
        lo_v = 1'b1;
        hi_v = 1'b0;
        commit();
        check("shadow_decimation", cic_decimation_o, 10);
        check("shadow_shift", cic_shift_o, 2);
        model_en = 1;
        sb_en = 1;
        out_ready_i = 1'b1;
        cfg_en_i = 1'b1;
        wait_pops(6, 6000, ok);
        check("stream_pops", ok, 1);
        check("settle_discarded", pulse_n, SETTLE + 3);

        // Overflow: two output pairs while stalled.
        step();
        check("queue_drained", exp_q.size(), 0);
        out_ready_i = 1'b0;
        p0 = pulse_n;
        wait_pulse(p0 + 2, 800, ok);
        check("ovf_pulses", ok, 1);
        step();
        step();
        check("ovf_set", overflow_o, 1);
        check("ovf_valid_held", out_valid_o, 1);
        check("ovf_ch_held", out_ch_o, 0);
        e16 = exp_q[0][15:0];
        check("ovf_data_held", out_data_o, e16);
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        out_ready_i = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
        check("ovf_drained", exp_q.size(), 0);
        check("ovf_sticky", overflow_o, 1);

        // Mid-period reconfiguration.
        for (int i = 0; i < 20 && !(h0 == 1'b0 && !cic_valid_o); i++) step();
        cfg_decimation_i = 10'd20;
        commit();
        check("dec_immediate", cic_decimation_o, 20);
        check("ovf_cleared", overflow_o, 0);
        check("no_update_yet", cic_update_o, 0);
        early = 0;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (cic_update_o) begin
                early = 1;
                break;
            end
            if (cic_valid_o) begin
                ok = 1;
                break;
            end
        end
        check("update_before_strobe", early, 0);
        check("period_end_strobe", ok, 1);
        step();
        check("update_after_strobe", cic_update_o, 1);
        step();
        check("update_one_cycle", cic_update_o, 0);
        check("busy_in_settle", busy_o, 1);
        p0 = pop_n;
        wait_pops(p0 + 2, 3000, ok);
        check("resettled_stream", ok, 1);
        check("resettle_discard", exp_q.size(), 0);

        // Stop with a ch1 sample still pending.
        out_ready_i = 1'b0;
        p0 = pulse_n;
        wait_pulse(p0 + 1, 400, ok);
        check("stop_pulse", ok, 1);
        step();
        step();
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;
        cfg_en_i = 1'b0;
        wait_strobe(20, ok);
        check("stop_strobe", ok, 1);
        step();
        step();
        check("stop_pdm_low", pdm_clk_o, 0);
        check("stop_busy", busy_o, 1);
        check("stop_pending_ch1", {out_valid_o, out_ch_o}, 2'b11);
        out_ready_i = 1'b1;
        for (int i = 0; i < 10 && busy_o; i++) step();
        check("stop_idle", busy_o, 0);
        check("stop_delivered", exp_q.size(), 0);
        check("stop_out_valid", out_valid_o, 0);
        check("stop_pdm_idle", pdm_clk_o, 0);

        // Asynchronous reset in the middle of RUN.
        cfg_en_i = 1'b1;
        p0 = pop_n;
        wait_pops(p0 + 2, 3000, ok);
        check("rerun_stream", ok, 1);
        out_ready_i = 1'b0;
        p0 = pulse_n;
        wait_pulse(p0 + 1, 400, ok);
        step();
        step();
        check("pre_reset_valid", out_valid_o, 1);
        #3;
        rstn_i = 1'b0;
        #1;
        sb_en = 0;
        exp_q.delete();
        check("arst_out_valid", out_valid_o, 0);
        check("arst_out_data", out_data_o, 0);
        check("arst_busy", busy_o, 0);
        check("arst_overflow", overflow_o, 0);
        check("arst_decimation", cic_decimation_o, 0);
        check("arst_cic_valid", cic_valid_o, 0);
        cfg_en_i = 1'b0;
        step();
        step();
        rstn_i = 1'b1;
        upd_seen = 0;
        for (int i = 0; i < 10; i++) step();
        check("arst_no_update", upd_seen, 0);
        check("arst_idle", busy_o, 0);
        check("arst_pdm_low", pdm_clk_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
